// File: rtl/imem_loader_if.sv
// Handshake and memory-load-port bundle between the byte source, the
// loader and the instruction memory.
interface imem_loader_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   num_words;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              le;
   logic [31:0]       load_addr;
   logic [31:0]       iin;
   logic              busy;
   logic              done;

   modport slave (
      input  start, base_addr, num_words, byte_in, byte_valid,
      output byte_ready, le, load_addr, iin, busy, done
   );

   modport master (
      output start, base_addr, num_words, byte_in, byte_valid,
      input  byte_ready, le, load_addr, iin, busy, done
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs an MSB-first byte stream into 32-bit
// words and writes them to consecutive word addresses.
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic         clk,
   input  logic         rst,
   imem_loader_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

   state_t            r_state, w_state_nxt;
   logic [1:0]        r_bidx;
   logic [ADDR_W:0]   r_wcnt, r_nwords;
   logic [ADDR_W-1:0] r_addr, r_ld_addr;
   logic [31:0]       r_word, r_iin;

   logic              w_start, w_accept;
   logic [ADDR_W:0]   w_wcnt_nxt;

   assign w_start    = bus.start && (r_state == S_IDLE || r_state == S_DONE);
   assign w_accept   = bus.byte_valid && (r_state == S_RECV);
   assign w_wcnt_nxt = r_wcnt + (ADDR_W+1)'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE:
            if (w_start) w_state_nxt = (bus.num_words == '0) ? S_DONE : S_RECV;
         S_RECV:
            if (w_accept && r_bidx == 2'd3) w_state_nxt = S_WRITE;
         S_WRITE:
            w_state_nxt = (w_wcnt_nxt == r_nwords) ? S_DONE : S_RECV;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.byte_ready = 1'b0;
      bus.le         = 1'b0;
      bus.busy       = 1'b0;
      bus.done       = 1'b0;
      case (r_state)
         S_RECV:  begin bus.byte_ready = 1'b1; bus.busy = 1'b1; end
         S_WRITE: begin bus.le = 1'b1; bus.busy = 1'b1; end
         S_DONE:  bus.done = 1'b1;
         default: ;
      endcase
   end

   // The write port is loaded on the 4th byte so it is stable for the whole
   // WRITE cycle; the running address advances during WRITE itself.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bidx    <= '0;
         r_wcnt    <= '0;
         r_nwords  <= '0;
         r_addr    <= '0;
         r_ld_addr <= '0;
         r_word    <= '0;
         r_iin     <= '0;
      end else begin
         if (w_start) begin
            r_addr   <= bus.base_addr;
            r_nwords <= bus.num_words;
            r_wcnt   <= '0;
            r_bidx   <= '0;
         end
         if (w_accept) begin
            r_word <= {r_word[23:0], bus.byte_in};
            r_bidx <= r_bidx + 2'd1;
            if (r_bidx == 2'd3) begin
               r_iin     <= {r_word[23:0], bus.byte_in};
               r_ld_addr <= r_addr;
            end
         end
         if (r_state == S_WRITE) begin
            r_wcnt <= w_wcnt_nxt;
            r_addr <= r_addr + ADDR_W'(1);
            r_bidx <= '0;
         end
      end
   end

   assign bus.load_addr = {{(32-ADDR_W){1'b0}}, r_ld_addr};
   assign bus.iin       = r_iin;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: single word, gapped multi-word, address
// wrap, zero length, mid-load reset and ignored start/byte inputs.
module tb_imem_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(10)) bus ();

   imem_loader #(.ADDR_W(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_rdy = 0;
   logic [31:0] q_addr[$];
   logic [31:0] q_data[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.le) begin
         q_addr.push_back(bus.load_addr);
         q_data.push_back(bus.iin);
      end
      if (bus.byte_ready) n_rdy <= n_rdy + 1;
   end

   logic [7:0] t2_b   [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h0F, 8'h5A, 8'hF0,
                               8'hDE, 8'hAD, 8'hBE, 8'hEF};
   int         t2_gap [12] = '{0, 2, 1, 0, 3, 0, 0, 1, 0, 1, 2, 0};
   logic [31:0] t2_w  [3]  = '{32'h11223344, 32'hA50F5AF0, 32'hDEADBEEF};
   logic [31:0] t3_a  [4]  = '{32'd1022, 32'd1023, 32'd0, 32'd1};
   logic [31:0] t3_w  [4]  = '{32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic ok;
      ok = 1'b0;
      bus.byte_valid = 1'b0;
      repeat (gap) tick();
      bus.byte_valid = 1'b1;
      bus.byte_in    = b;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = bus.byte_ready;
         tick();
      end
      if (!ok) chk("byte_hs_timeout", 32'd0, 32'd1);
      bus.byte_valid = 1'b0;
   endtask

   task automatic wait_done(input int max);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         if (bus.done) seen = 1'b1;
         else tick();
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_start(input logic [9:0] base, input logic [10:0] nw);
      bus.start      = 1'b1;
      bus.base_addr  = base;
      bus.num_words  = nw;
      bus.byte_valid = 1'b0;
      tick();
      bus.start = 1'b0;
   endtask

   initial begin
      int qb, t0, rb;
      bus.start = 1'b0; bus.base_addr = '0; bus.num_words = '0;
      bus.byte_in = '0; bus.byte_valid = 1'b0;

      // reset state
      #1;
      chk("rst_le",    {31'd0, bus.le}, 32'd0);
      chk("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
      chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
      chk("rst_done",  {31'd0, bus.done}, 32'd0);
      chk("rst_addr",  bus.load_addr, 32'd0);
      chk("rst_iin",   bus.iin, 32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // single word at address 5
      qb = q_addr.size();
      do_start(10'd5, 11'd1);
      t0 = cyc;
      chk("t1_busy",  {31'd0, bus.busy}, 32'd1);
      chk("t1_ready", {31'd0, bus.byte_ready}, 32'd1);
      send_byte(8'h20, 0); send_byte(8'h08, 0);
      send_byte(8'h00, 0); send_byte(8'h0A, 0);
      chk("t1_le",   {31'd0, bus.le}, 32'd1);
      chk("t1_addr", bus.load_addr, 32'd5);
      chk("t1_iin",  bus.iin, 32'h2008000A);
      tick();
      chk("t1_done",   {31'd0, bus.done}, 32'd1);
      chk("t1_idle",   {31'd0, bus.busy}, 32'd0);
      chk("t1_le_off", {31'd0, bus.le}, 32'd0);
      // start edge N, done after edge N+5: cycles N..N+5
      chk("t1_edges",  32'(cyc - t0), 32'd5);
      chk("t1_npulse", 32'(q_addr.size() - qb), 32'd1);

      // three words with bubbles and an ignored start mid-load
      qb = q_addr.size();
      do_start(10'd0, 11'd3);
      for (int i = 0; i < 12; i++) begin
         send_byte(t2_b[i], t2_gap[i]);
         if (i == 5) begin
            bus.start = 1'b1; bus.base_addr = 10'd77; bus.num_words = 11'd1;
            tick();
            bus.start = 1'b0;
         end
      end
      wait_done(20);
      chk("t2_npulse", 32'(q_addr.size() - qb), 32'd3);
      for (int i = 0; i < 3 && qb + i < q_addr.size(); i++) begin
         chk($sformatf("t2_addr%0d", i), q_addr[qb+i], 32'(i));
         chk($sformatf("t2_word%0d", i), q_data[qb+i], t2_w[i]);
      end

      // byte_valid in DONE is not consumed
      qb = q_addr.size();
      rb = n_rdy;
      bus.byte_valid = 1'b1; bus.byte_in = 8'hFF;
      repeat (4) tick();
      chk("done_ready", 32'(n_rdy - rb), 32'd0);
      chk("done_hold",  {31'd0, bus.done}, 32'd1);
      chk("done_nole",  32'(q_addr.size() - qb), 32'd0);

      // start from DONE, address wrap 1022 -> 1
      do_start(10'd1022, 11'd4);
      chk("t3_done_clr", {31'd0, bus.done}, 32'd0);
      chk("t3_busy",     {31'd0, bus.busy}, 32'd1);
      for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), i % 2);
      wait_done(20);
      chk("t3_npulse", 32'(q_addr.size() - qb), 32'd4);
      for (int i = 0; i < 4 && qb + i < q_addr.size(); i++) begin
         chk($sformatf("t3_addr%0d", i), q_addr[qb+i], t3_a[i]);
         chk($sformatf("t3_word%0d", i), q_data[qb+i], t3_w[i]);
      end

      // zero length from IDLE
      rst = 1'b1; tick(); rst = 1'b0; tick();
      qb = q_addr.size();
      rb = n_rdy;
      chk("t4_pre_done", {31'd0, bus.done}, 32'd0);
      do_start(10'd9, 11'd0);
      chk("t4_done", {31'd0, bus.done}, 32'd1);
      chk("t4_busy", {31'd0, bus.busy}, 32'd0);
      repeat (3) tick();
      chk("t4_noready", 32'(n_rdy - rb), 32'd0);
      chk("t4_nole",    32'(q_addr.size() - qb), 32'd0);

      // reset after 2 bytes of the second word
      qb = q_addr.size();
      do_start(10'd10, 11'd3);
      send_byte(8'h01, 0); send_byte(8'h02, 0);
      send_byte(8'h03, 0); send_byte(8'h04, 0);
      tick();
      send_byte(8'h05, 0); send_byte(8'h06, 0);
      rst = 1'b1;
      #1;
      chk("t5_le",    {31'd0, bus.le}, 32'd0);
      chk("t5_ready", {31'd0, bus.byte_ready}, 32'd0);
      chk("t5_busy",  {31'd0, bus.busy}, 32'd0);
      chk("t5_done",  {31'd0, bus.done}, 32'd0);
      chk("t5_addr",  bus.load_addr, 32'd0);
      chk("t5_iin",   bus.iin, 32'd0);
      tick();
      rst = 1'b0;
      bus.byte_valid = 1'b1; bus.byte_in = 8'hEE;
      repeat (6) tick();
      bus.byte_valid = 1'b0;
      chk("t5_nole", 32'(q_addr.size() - qb), 32'd1);
      do_start(10'd200, 11'd1);
      send_byte(8'hCA, 0); send_byte(8'hFE, 0);
      send_byte(8'hF0, 0); send_byte(8'h0D, 0);
      tick();
      chk("t5_redone", {31'd0, bus.done}, 32'd1);
      chk("t5_npulse", 32'(q_addr.size() - qb), 32'd2);
      if (q_addr.size() == qb + 2) begin
         chk("t5_addr2", q_addr[qb+1], 32'd200);
         chk("t5_word2", q_data[qb+1], 32'hCAFEF00D);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
